// File: rtl/dcache_store_port.sv
// Write-side port of a direct-mapped, write-back, write-allocate data cache.
// Store hits retire in one cycle; misses write back a dirty victim, fill the line, and merge the store.
module dcache_store_port #(
    parameter int INDEX_BITS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sending_data_to_cache,
    input  logic [63:0]  data_to_cache,
    output logic         cache_ready_to_catch,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    state_t                  state_r;
    logic [LINES-1:0]        valid_r;
    logic [LINES-1:0]        dirty_r;
    logic [TAG_W-1:0]        tag_r [LINES];
    logic [127:0]            line_data_r [LINES];
    logic [TAG_W-1:0]        pend_tag_r;
    logic [INDEX_BITS-1:0]   pend_index_r;
    logic [1:0]              pend_word_r;
    logic [31:0]             pend_data_r;

    logic [31:0]             in_data_s;
    logic [1:0]              in_word_s;
    logic [INDEX_BITS-1:0]   in_index_s;
    logic [TAG_W-1:0]        in_tag_s;
    logic                    byte_offset_unused_s;
    logic                    accept_s;
    logic                    hit_s;
    logic                    miss_s;
    logic                    victim_dirty_s;
    logic                    fill_done_s;
    logic [127:0]            hit_line_s;
    logic [127:0]            fill_line_s;

    // Replace one 32-bit word of a line, word 0 in the low bits.
    function automatic logic [127:0] merge_word(input logic [127:0] line,
                                                input logic [1:0]   word,
                                                input logic [31:0]  data);
        logic [127:0] merged;
        merged = line;
        merged[{word, 5'd0} +: 32] = data;
        return merged;
    endfunction

    assign in_data_s            = data_to_cache[31:0];
    assign in_word_s            = data_to_cache[35:34];
    assign in_index_s           = data_to_cache[32+3+INDEX_BITS:32+4];
    assign in_tag_s             = data_to_cache[63:32+4+INDEX_BITS];
    assign byte_offset_unused_s = ^data_to_cache[33:32];

    // Handshake decode, hit detection and line merges.
    always_comb begin
        accept_s       = sending_data_to_cache & cache_ready_to_catch;
        hit_s          = accept_s & valid_r[in_index_s] & (tag_r[in_index_s] == in_tag_s);
        miss_s         = accept_s & ~hit_s;
        victim_dirty_s = valid_r[in_index_s] & dirty_r[in_index_s];
        fill_done_s    = (state_r == ST_FILL) & mem_ready;
        hit_line_s     = merge_word(line_data_r[in_index_s], in_word_s, in_data_s);
        fill_line_s    = merge_word(mem_rdata, pend_word_r, pend_data_r);
    end

    // Line data array; contents are don't-care until the valid bit is set.
    always_ff @(posedge clk) begin
        if (hit_s) begin
            line_data_r[in_index_s] <= hit_line_s;
        end else if (fill_done_s) begin
            line_data_r[pend_index_r] <= fill_line_s;
        end
    end

    // Control FSM, line metadata, pending entry, memory outputs and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r              <= ST_IDLE;
            cache_ready_to_catch <= 1'b1;
            mem_req              <= 1'b0;
            mem_we               <= 1'b0;
            mem_addr             <= 32'd0;
            mem_wdata            <= 128'd0;
            valid_r              <= {LINES{1'b0}};
            dirty_r              <= {LINES{1'b0}};
            for (int i = 0; i < LINES; i++) begin
                tag_r[i] <= {TAG_W{1'b0}};
            end
            pend_tag_r           <= {TAG_W{1'b0}};
            pend_index_r         <= {INDEX_BITS{1'b0}};
            pend_word_r          <= 2'd0;
            pend_data_r          <= 32'd0;
            hit_count            <= 16'd0;
            miss_count           <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hit_s) begin
                        dirty_r[in_index_s] <= 1'b1;
                        if (hit_count != 16'hFFFF) begin
                            hit_count <= hit_count + 16'd1;
                        end
                    end else if (miss_s) begin
                        pend_tag_r           <= in_tag_s;
                        pend_index_r         <= in_index_s;
                        pend_word_r          <= in_word_s;
                        pend_data_r          <= in_data_s;
                        cache_ready_to_catch <= 1'b0;
                        mem_req              <= 1'b1;
                        if (miss_count != 16'hFFFF) begin
                            miss_count <= miss_count + 16'd1;
                        end
                        if (victim_dirty_s) begin
                            state_r   <= ST_WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_r[in_index_s], in_index_s, 4'b0000};
                            mem_wdata <= line_data_r[in_index_s];
                        end else begin
                            state_r  <= ST_FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {in_tag_s, in_index_s, 4'b0000};
                        end
                    end
                end
                ST_WB: begin
                    if (mem_ready) begin
                        dirty_r[pend_index_r] <= 1'b0;
                        state_r               <= ST_FILL;
                        mem_we                <= 1'b0;
                        mem_addr              <= {pend_tag_r, pend_index_r, 4'b0000};
                    end
                end
                ST_FILL: begin
                    // Pending store is merged into the fill, so the line comes back dirty.
                    if (mem_ready) begin
                        valid_r[pend_index_r] <= 1'b1;
                        dirty_r[pend_index_r] <= 1'b1;
                        tag_r[pend_index_r]   <= pend_tag_r;
                        state_r               <= ST_IDLE;
                        mem_req               <= 1'b0;
                        cache_ready_to_catch  <= 1'b1;
                    end
                end
                default: begin
                    state_r              <= ST_IDLE;
                    mem_req              <= 1'b0;
                    mem_we               <= 1'b0;
                    cache_ready_to_catch <= 1'b1;
                end
            endcase
        end
    end

endmodule
